// File: rtl/wb_write_queue_if.sv
// Producer, register-file write and bypass-lookup signals of the write-back queue.
// The master side drives results, drain enable and lookup addresses; the slave side is the queue.
interface wb_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;

  logic              drain_en;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;

  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_valid, ld_reg, ld_data,
    output drain_en, ReadRegister1, ReadRegister2,
    input  alu_ready, ld_ready,
    input  RegWrite, WriteRegister, WriteData,
    input  byp_hit1, byp_data1, byp_hit2, byp_data2,
    input  count, full, empty
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_valid, ld_reg, ld_data,
    input  drain_en, ReadRegister1, ReadRegister2,
    output alu_ready, ld_ready,
    output RegWrite, WriteRegister, WriteData,
    output byp_hit1, byp_data1, byp_hit2, byp_data2,
    output count, full, empty
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue merging ALU and load results onto the single register-file write port,
// with a combinational youngest-match bypass so the read stage sees values still queued.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            reset,
  wb_write_queue_if.slave wq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  logic [ADDR_W-1:0] entryReg  [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  occCount;

  logic              isFull;
  logic              isEmpty;
  logic              ldFire;
  logic              aluFire;
  logic              doPush;
  logic              doPop;
  logic [ADDR_W-1:0] enqReg;
  logic [DATA_W-1:0] enqData;

  assign isFull  = (occCount == CNT_W'(DEPTH));
  assign isEmpty = (occCount == '0);

  // Readiness comes from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign wq.ld_ready  = !isFull;
  assign wq.alu_ready = !isFull && !wq.ld_valid;

  assign ldFire  = wq.ld_valid && !isFull;
  assign aluFire = wq.alu_valid && !isFull && !wq.ld_valid;

  always_comb begin
    enqReg  = wq.alu_reg;
    enqData = wq.alu_data;
    if (wq.ld_valid) begin
      enqReg  = wq.ld_reg;
      enqData = wq.ld_data;
    end
  end

  // Writes to x31 complete the handshake but occupy no slot.
  assign doPush = (ldFire || aluFire) && (enqReg != ZERO_REG);
  assign doPop  = !isEmpty && wq.drain_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      occCount <= '0;
    end else begin
      if (doPush) begin
        tailPtr <= tailPtr + PTR_W'(1);
      end
      if (doPop) begin
        headPtr <= headPtr + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        occCount <= occCount + CNT_W'(1);
      end else if (doPop && !doPush) begin
        occCount <= occCount - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      entryReg[tailPtr]  <= enqReg;
      entryData[tailPtr] <= enqData;
    end
  end

  assign wq.RegWrite      = doPop;
  assign wq.WriteRegister = entryReg[headPtr];
  assign wq.WriteData     = entryData[headPtr];

  assign wq.count = occCount;
  assign wq.full  = isFull;
  assign wq.empty = isEmpty;

  logic [ADDR_W-1:0] lookAddr [2];
  logic              lookHit  [2];
  logic [DATA_W-1:0] lookData [2];

  assign lookAddr[0] = wq.ReadRegister1;
  assign lookAddr[1] = wq.ReadRegister2;

  // Walk oldest to youngest so the last match (the youngest) wins; the head is included.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lookHit[p]  = 1'b0;
      lookData[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < occCount) &&
            (lookAddr[p] != ZERO_REG) &&
            (entryReg[headPtr + PTR_W'(i)] == lookAddr[p])) begin
          lookHit[p]  = 1'b1;
          lookData[p] = entryData[headPtr + PTR_W'(i)];
        end
      end
    end
  end

  assign wq.byp_hit1  = lookHit[0];
  assign wq.byp_data1 = lookData[0];
  assign wq.byp_hit2  = lookHit[1];
  assign wq.byp_data2 = lookData[1];

  a_count_bound: assert property (@(posedge clk) disable iff (reset) occCount <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) isFull |-> !doPush);

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed tests for wb_write_queue; a negedge monitor checks every register-file write
// against a scoreboard queue filled by the stimulus.
module tb_wb_write_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wq();

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .wq    (wq.slave)
  );

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
    bit          chkLat;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] rf [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write presented to the register file must match the oldest expected entry.
  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    forever begin
      @(negedge clk);
      if (!reset && wq.RegWrite) begin
        rf[wq.WriteRegister] = wq.WriteData;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                   wq.WriteRegister, wq.WriteData);
        end else begin
          e = sbQ.pop_front();
          check("wr_reg", wq.WriteRegister, e.r);
          check("wr_data", wq.WriteData, e.d);
          if (e.chkLat) check("wr_latency_cycle", cyc, e.cyc + 1);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [63:0] d, input bit lat);
    exp_t e;
    e.r = r;
    e.d = d;
    e.chkLat = lat;
    e.cyc = cyc;
    sbQ.push_back(e);
  endtask

  // One-cycle offer from a producer; call right after a posedge, returns right after the next one.
  task automatic send(input bit isLd, input logic [4:0] r, input logic [63:0] d,
                      input bit expRdy, input bit lat);
    if (isLd) begin
      wq.ld_valid = 1'b1; wq.ld_reg = r; wq.ld_data = d;
    end else begin
      wq.alu_valid = 1'b1; wq.alu_reg = r; wq.alu_data = d;
    end
    @(negedge clk);
    if (isLd) check("ld_ready", wq.ld_ready, expRdy);
    else      check("alu_ready", wq.alu_ready, expRdy);
    if (expRdy && r != 5'd31) expectWrite(r, d, lat);
    sync();
    wq.ld_valid  = 1'b0;
    wq.alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wq.alu_valid = 0; wq.alu_reg = 0; wq.alu_data = 0;
    wq.ld_valid = 0;  wq.ld_reg = 0;  wq.ld_data = 0;
    wq.drain_en = 0;  wq.ReadRegister1 = 0; wq.ReadRegister2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_RegWrite", wq.RegWrite, 0);
    check("rst_empty", wq.empty, 1);
    check("rst_full", wq.full, 0);
    check("rst_count", wq.count, 0);
    check("rst_byp_hit1", wq.byp_hit1, 0);
    check("rst_byp_hit2", wq.byp_hit2, 0);
    check("rst_ld_ready", wq.ld_ready, 1);

    // 1: single load, minimum latency
    sync();
    wq.drain_en = 1'b1;
    send(1, 5'd3, 64'hAA, 1, 1);
    repeat (2) @(negedge clk);
    check("t1_rf_r3", rf[3], 64'hAA);
    check("t1_empty", wq.empty, 1);

    // 2: load has priority over ALU
    sync();
    wq.alu_valid = 1; wq.alu_reg = 5'd1; wq.alu_data = 64'h11;
    wq.ld_valid = 1;  wq.ld_reg = 5'd2;  wq.ld_data = 64'h22;
    @(negedge clk);
    check("t2_ld_ready", wq.ld_ready, 1);
    check("t2_alu_ready", wq.alu_ready, 0);
    expectWrite(5'd2, 64'h22, 0);
    sync();
    wq.ld_valid = 0;
    @(negedge clk);
    check("t2_alu_ready_after", wq.alu_ready, 1);
    expectWrite(5'd1, 64'h11, 0);
    sync();
    wq.alu_valid = 0;
    repeat (3) @(negedge clk);
    check("t2_rf_r1", rf[1], 64'h11);
    check("t2_rf_r2", rf[2], 64'h22);

    // 3: fill, refuse when full, then drain one per cycle
    sync();
    wq.drain_en = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 5'(4 + k), 64'h100 + 64'(k), 1, 0);
    @(negedge clk);
    check("t3_full", wq.full, 1);
    check("t3_count", wq.count, 4);
    check("t3_alu_ready_full", wq.alu_ready, 0);
    sync();
    send(1, 5'd20, 64'hDEAD, 0, 0);
    wq.drain_en = 1'b1;
    @(negedge clk);
    check("t3_ready_during_pop", wq.ld_ready, 0);
    check("t3_count_pop0", wq.count, 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t3_count_drain", wq.count, 64'(4 - k));
    end
    check("t3_empty", wq.empty, 1);

    // 4: bypass youngest match, x31 and miss
    sync();
    wq.drain_en = 1'b0;
    send(1, 5'd5, 64'h1, 1, 0);
    send(0, 5'd5, 64'h2, 1, 0);
    wq.ReadRegister1 = 5'd5;
    wq.ReadRegister2 = 5'd31;
    #1;
    check("t4_hit1", wq.byp_hit1, 1);
    check("t4_data1", wq.byp_data1, 64'h2);
    check("t4_hit2_x31", wq.byp_hit2, 0);
    check("t4_data2_x31", wq.byp_data2, 0);
    wq.ReadRegister2 = 5'd9;
    #1;
    check("t4_hit2_miss", wq.byp_hit2, 0);
    wq.drain_en = 1'b1;
    @(negedge clk);
    check("t4_hit1_draining", wq.byp_data1, 64'h2);
    @(negedge clk);
    check("t4_hit1_head", wq.byp_hit1, 1);
    check("t4_data1_head", wq.byp_data1, 64'h2);
    @(negedge clk);
    check("t4_hit1_gone", wq.byp_hit1, 0);
    check("t4_data1_gone", wq.byp_data1, 0);

    // 5: x31 writes are accepted and dropped
    sync();
    send(1, 5'd31, 64'hA0, 1, 0);
    @(negedge clk);
    check("t5_count_ld", wq.count, 0);
    check("t5_RegWrite", wq.RegWrite, 0);
    sync();
    send(0, 5'd31, 64'hB0, 1, 0);
    @(negedge clk);
    check("t5_empty_alu", wq.empty, 1);

    // 6: reset discards pending entries
    sync();
    wq.drain_en = 1'b0;
    for (int k = 0; k < 3; k++) send(1, 5'(12 + k), 64'hC0 + 64'(k), 1, 0);
    @(negedge clk);
    check("t6_count_pre", wq.count, 3);
    sync();
    reset = 1'b1;
    sbQ.delete();
    sync();
    reset = 1'b0;
    wq.drain_en = 1'b1;
    wq.ReadRegister1 = 5'd12;
    @(negedge clk);
    check("t6_count", wq.count, 0);
    check("t6_RegWrite", wq.RegWrite, 0);
    check("t6_hit1", wq.byp_hit1, 0);
    repeat (4) @(negedge clk);
    check("t6_rf_r12", rf[12], 0);
    check("t6_rf_r14", rf[14], 0);
    check("rf_r31", rf[31], 0);

    check("sb_drained", 64'(sbQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
